smpl_dmem_ctrl: RTL and testbench
=================================

SMPL_DMEM_CTRL -- requirements
Module: smpl_dmem_ctrl

Interface
REQ-001 SHALL have parameter AW, default 13, data address width in bits.
REQ-002 SHALL have parameter DW, default 16, data word width in bits.
REQ-003 SHALL have parameter RAM_LOG2, default 10, log2 of internal RAM depth in words.
REQ-004 SHALL have port: clock  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-low reset; asserted at 0.
REQ-006 SHALL have port: daddr  in  AW  word address from core data port.
REQ-007 SHALL have port: datao  in  DW  write data from core.
REQ-008 SHALL have port: renbl  in  1  read request from core.
REQ-009 SHALL have port: wenbl  in  1  write request from core.
REQ-010 SHALL have port: datai  out  DW  registered read data returned to core.
REQ-011 SHALL have port: dready  out  1  one-cycle completion strobe for the accepted access.
REQ-012 SHALL have port: gpio_in  in  DW  asynchronous external input port.
REQ-013 SHALL have port: gpio_out  out  DW  registered output port.
REQ-014 SHALL have port: err  out  1  sticky access-error flag.

Function
REQ-015 SHALL implement FSM states IDLE, RACK, WACK; only IDLE accepts requests.
REQ-016 SHALL, in IDLE with renbl=1 and wenbl=0, capture decoded read data into datai and go to RACK.
REQ-017 SHALL, in IDLE with wenbl=1, perform the write on that edge and go to WACK.
REQ-018 SHALL assert dready=1 for exactly one cycle in RACK or WACK, then return to IDLE (latency 1 cycle, throughput 1 access per 2 cycles).
REQ-019 SHALL ignore renbl/wenbl while in RACK or WACK; core holds request until dready.
REQ-020 SHALL map 0 .. 2^RAM_LOG2-1 to internal RAM (read/write).
REQ-021 SHALL map 0x1FFF to gpio_out register (read returns current gpio_out; write updates it).
REQ-022 SHALL map 0x1FFE to gpio_in via two-flop synchronizer (read-only; writes discarded, err set).
REQ-023 SHALL map 0x1FFD to a free-running DW-bit cycle counter incrementing every cycle, wrapping 0xFFFF->0x0000; write of any value clears it to 0 on that edge with no increment that cycle.
REQ-024 SHALL treat any other address as unmapped: read returns 0x0000, write discarded, err set.
REQ-025 SHALL, on renbl=1 and wenbl=1 together in IDLE, perform the write only, set err, and go to WACK.
REQ-026 SHALL hold datai unchanged except on entry to RACK.
REQ-027 SHALL keep err set until reset; no software clear.
REQ-028 SHALL leave RAM contents unchanged after a write to non-RAM addresses.

Reset
REQ-029 SHALL, while reset=0, force state IDLE, datai=0x0000, dready=0, gpio_out=0x0000, err=0, counter=0, synchronizer flops=0.
REQ-030 SHALL abort any access in RACK/WACK on reset assertion; a write already committed in IDLE stays committed.
REQ-031 SHALL NOT clear RAM contents on reset.
REQ-032 SHALL accept first request on the first rising edge after reset deasserts.

Verification
REQ-033 Write 0x1234 to 0x0005, then read 0x0005 -> dready pulses one cycle after each request; datai=0x1234 with second dready.
REQ-034 Write 0xBEEF to 0x1FFF -> gpio_out=0xBEEF the cycle after the edge; read 0x1FFF returns 0xBEEF; err=0.
REQ-035 gpio_in=0x00A5 held 3 cycles, read 0x1FFE -> datai=0x00A5; then write 0x1FFE -> err=1, gpio_in sync unaffected.
REQ-036 Read 0x1000 (unmapped) -> datai=0x0000, err=1 and remains 1 across later valid accesses until reset=0.
REQ-037 renbl=wenbl=1, daddr=0x0003, datao=0x0F0F -> state WACK, RAM[3]=0x0F0F, err=1, datai unchanged.
REQ-038 Write 0 to 0x1FFD, wait 0x10000 cycles, read 0x1FFD -> value equals elapsed-cycle count modulo 2^16 (wrap verified); reset asserted during RACK -> dready=0, datai=0x0000 immediately.

Source files
------------

// File: rtl/smpl_dmem_ctrl.sv
// Data-memory controller for a simple core.
// Decodes one word address into four regions: internal RAM, a GPIO output register,
// a synchronised GPIO input, and a free-running cycle counter. Each access is
// accepted in IDLE and completed one cycle later with a single dready pulse.
//
// Ports
//   clock     in   single clock, rising edge
//   reset     in   asynchronous active-low reset
//   daddr     in   AW-bit word address from the core
//   datao     in   DW-bit write data from the core
//   renbl     in   read request
//   wenbl     in   write request (wins over renbl when both are set)
//   datai     out  registered read data
//   dready    out  one-cycle completion strobe
//   gpio_in   in   asynchronous external input
//   gpio_out  out  registered output port
//   err       out  sticky access-error flag
module smpl_dmem_ctrl #(
  parameter int unsigned AW       = 13,
  parameter int unsigned DW       = 16,
  parameter int unsigned RAM_LOG2 = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] datao,
  input  logic          renbl,
  input  logic          wenbl,
  output logic [DW-1:0] datai,
  output logic          dready,
  input  logic [DW-1:0] gpio_in,
  output logic [DW-1:0] gpio_out,
  output logic          err
);

  localparam logic [AW-1:0] AddrGpioOut = AW'(13'h1FFF);
  localparam logic [AW-1:0] AddrGpioIn  = AW'(13'h1FFE);
  localparam logic [AW-1:0] AddrCnt     = AW'(13'h1FFD);

  typedef enum logic [1:0] {StIdle, StRack, StWack} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] datai_q, datai_d;
  logic          dready_q, dready_d;
  logic [DW-1:0] gpio_out_q, gpio_out_d;
  logic          err_q, err_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] gin_meta_q, gin_sync_q;

  // RAM has no reset: contents survive reset assertion.
  logic [DW-1:0] mem_q [2**RAM_LOG2];

  logic                is_gout, is_gin, is_cnt, is_ram, is_unmapped;
  logic [RAM_LOG2-1:0] ram_idx;
  logic                idle, do_wr, do_rd;
  logic [DW-1:0]       rd_data;

  // Address decode; the fixed I/O addresses take precedence over RAM.
  always_comb begin
    is_gout     = (daddr == AddrGpioOut);
    is_gin      = (daddr == AddrGpioIn);
    is_cnt      = (daddr == AddrCnt);
    is_ram      = !(is_gout || is_gin || is_cnt) && ((daddr >> RAM_LOG2) == '0);
    is_unmapped = !(is_gout || is_gin || is_cnt || is_ram);
    ram_idx     = daddr[RAM_LOG2-1:0];
  end

  always_comb begin
    idle  = (state_q == StIdle);
    do_wr = idle && wenbl;
    do_rd = idle && renbl && !wenbl;
  end

  always_comb begin
    rd_data = '0;
    if (is_ram) begin
      rd_data = mem_q[ram_idx];
    end else if (is_gout) begin
      rd_data = gpio_out_q;
    end else if (is_gin) begin
      rd_data = gin_sync_q;
    end else if (is_cnt) begin
      rd_data = cnt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (do_wr) begin
          state_d = StWack;
        end else if (do_rd) begin
          state_d = StRack;
        end
      end
      StRack:  state_d = StIdle;
      StWack:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // dready is high exactly while in RACK/WACK.
    dready_d   = do_wr || do_rd;
    datai_d    = do_rd ? rd_data : datai_q;
    gpio_out_d = (do_wr && is_gout) ? datao : gpio_out_q;
    // A counter write clears it with no increment on that edge.
    cnt_d      = (do_wr && is_cnt) ? '0 : cnt_q + 1'b1;

    err_d = err_q;
    if (idle) begin
      if ((renbl && wenbl) || (wenbl && is_gin) || ((renbl || wenbl) && is_unmapped)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      datai_q    <= '0;
      dready_q   <= 1'b0;
      gpio_out_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      gin_meta_q <= '0;
      gin_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      datai_q    <= datai_d;
      dready_q   <= dready_d;
      gpio_out_q <= gpio_out_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      gin_meta_q <= gpio_in;
      gin_sync_q <= gin_meta_q;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr && is_ram) begin
      mem_q[ram_idx] <= datao;
    end
  end

  assign datai    = datai_q;
  assign dready   = dready_q;
  assign gpio_out = gpio_out_q;
  assign err      = err_q;

endmodule

// File: tb/tb_smpl_dmem_ctrl.sv
// Directed bench for smpl_dmem_ctrl. A transaction-level model (memory array,
// register copies, counter clear timestamp) predicts outputs; a compare process
// checks them every falling edge, and literal checks pin the model.
module tb_smpl_dmem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [12:0] daddr;
  logic [15:0] datao;
  logic        renbl, wenbl;
  logic [15:0] datai;
  logic        dready;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        err;

  smpl_dmem_ctrl #(
    .AW      (13),
    .DW      (16),
    .RAM_LOG2(10)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .daddr   (daddr),
    .datao   (datao),
    .renbl   (renbl),
    .wenbl   (wenbl),
    .datai   (datai),
    .dready  (dready),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .err     (err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  // Model state
  logic [15:0] mdl_mem [0:1023];
  logic [15:0] exp_datai  = '0;
  logic        exp_dready = 1'b0;
  logic [15:0] exp_gpio   = '0;
  logic        exp_err    = 1'b0;
  int          edge_n     = 0;  // counts falling edges; stable across each rising edge
  int          clr_edge   = 0;

  always @(negedge clock) edge_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!done) begin
      chk("datai", {16'h0, datai}, {16'h0, exp_datai});
      chk("dready", {31'h0, dready}, {31'h0, exp_dready});
      chk("gpio_out", {16'h0, gpio_out}, {16'h0, exp_gpio});
      chk("err", {31'h0, err}, {31'h0, exp_err});
    end
  end

  function automatic logic [15:0] model_read(input logic [12:0] a);
    logic [15:0] v;
    if (a < 13'd1024)         v = mdl_mem[a];
    else if (a == 13'h1FFF)   v = exp_gpio;
    else if (a == 13'h1FFE)   v = gpio_in;
    else if (a == 13'h1FFD)   v = 16'(edge_n - clr_edge - 1);
    else                      v = 16'h0000;
    return v;
  endfunction

  // One full access: request held until dready, then released.
  task automatic access(input logic rd, input logic wr, input logic [12:0] a,
                        input logic [15:0] d);
    renbl = rd;
    wenbl = wr;
    daddr = a;
    datao = d;
    @(posedge clock);
    if (wr) begin
      if (a < 13'd1024)       mdl_mem[a] = d;
      else if (a == 13'h1FFF) exp_gpio = d;
      else if (a == 13'h1FFD) clr_edge = edge_n;
      else                    exp_err = 1'b1;
      if (rd) exp_err = 1'b1;
    end else if (rd) begin
      exp_datai = model_read(a);
      if (!(a < 13'd1024 || a == 13'h1FFF || a == 13'h1FFE || a == 13'h1FFD)) exp_err = 1'b1;
    end
    exp_dready = 1'b1;
    @(negedge clock);
    renbl = 1'b0;
    wenbl = 1'b0;
    @(posedge clock);
    exp_dready = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset   = 1'b0;
    daddr   = '0;
    datao   = '0;
    renbl   = 1'b0;
    wenbl   = 1'b0;
    gpio_in = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // RAM write then read back
    access(1'b0, 1'b1, 13'h0005, 16'h1234);
    access(1'b1, 1'b0, 13'h0005, 16'h0000);
    chk("lit_ram5", {16'h0, datai}, 32'h1234);

    // GPIO output register
    access(1'b0, 1'b1, 13'h1FFF, 16'hBEEF);
    chk("lit_gpio_out", {16'h0, gpio_out}, 32'hBEEF);
    access(1'b1, 1'b0, 13'h1FFF, 16'h0000);
    chk("lit_gpio_rd", {16'h0, datai}, 32'hBEEF);
    chk("lit_err0", {31'h0, err}, 32'h0);

    // GPIO input through synchroniser; writing it is an error
    gpio_in = 16'h00A5;
    repeat (3) @(negedge clock);
    access(1'b1, 1'b0, 13'h1FFE, 16'h0000);
    chk("lit_gpio_in", {16'h0, datai}, 32'h00A5);
    access(1'b0, 1'b1, 13'h1FFE, 16'h3333);
    chk("lit_err_gin_wr", {31'h0, err}, 32'h1);
    access(1'b1, 1'b0, 13'h1FFE, 16'h0000);
    chk("lit_gpio_in2", {16'h0, datai}, 32'h00A5);

    // Unmapped read, then valid accesses keep err sticky
    access(1'b1, 1'b0, 13'h1000, 16'h0000);
    chk("lit_unmapped", {16'h0, datai}, 32'h0000);
    access(1'b0, 1'b1, 13'h0007, 16'h5555);
    access(1'b1, 1'b0, 13'h0007, 16'h0000);
    chk("lit_ram7", {16'h0, datai}, 32'h5555);
    chk("lit_err_sticky", {31'h0, err}, 32'h1);

    // Simultaneous read+write: write only, datai unchanged
    access(1'b1, 1'b1, 13'h0003, 16'h0F0F);
    chk("lit_rw_datai", {16'h0, datai}, 32'h5555);
    access(1'b1, 1'b0, 13'h0003, 16'h0000);
    chk("lit_ram3", {16'h0, datai}, 32'h0F0F);

    // Counter: clear then immediate read returns 1 (one increment between edges)
    access(1'b0, 1'b1, 13'h1FFD, 16'hABCD);
    access(1'b1, 1'b0, 13'h1FFD, 16'h0000);
    chk("lit_cnt_short", {16'h0, datai}, 32'h0001);

    // Counter wrap: 0x10000 extra cycles bring the same reading back
    access(1'b0, 1'b1, 13'h1FFD, 16'h0000);
    repeat (65536) @(negedge clock);
    access(1'b1, 1'b0, 13'h1FFD, 16'h0000);
    chk("lit_cnt_wrap", {16'h0, datai}, 32'h0001);

    // Reset during RACK clears outputs immediately
    renbl = 1'b1;
    wenbl = 1'b0;
    daddr = 13'h0005;
    @(posedge clock);
    #2;
    reset      = 1'b0;
    exp_datai  = '0;
    exp_dready = 1'b0;
    exp_gpio   = '0;
    exp_err    = 1'b0;
    #1;
    chk("lit_rst_dready", {31'h0, dready}, 32'h0);
    chk("lit_rst_datai", {16'h0, datai}, 32'h0000);
    renbl = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // RAM survives reset; first edge after release accepts the request
    access(1'b1, 1'b0, 13'h0005, 16'h0000);
    chk("lit_ram5_after_rst", {16'h0, datai}, 32'h1234);
    chk("lit_err_after_rst", {31'h0, err}, 32'h0);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
